// File: rtl/cmps2_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : cmps2_i2c_target
// Purpose  : I2C target emulating the Pmod CMPS2 (MMC34160PJ) register map.
//            Field values arrive on input ports, are captured at the end of
//            each TM_M measurement and served by multi-byte reads.
// Ports    : clk, rst             - system clock, synchronous active-high reset
//            scl_in, sda_in       - raw asynchronous bus lines
//            sda_drive_low        - 1 = pull SDA low (open drain)
//            field_x/y/z          - signed field values sampled at completion
//            meas_busy            - measurement counter running
//            cmd_valid, cmd_data  - pulse / byte for each CTRL0 write
// Revision : 1.0 - initial release
// ============================================================================
module cmps2_i2c_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h30,
  parameter logic [7:0]  PRODUCT_ID  = 8'h06,
  parameter int unsigned MEAS_CYCLES = 800_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_drive_low,
  input  logic [15:0] field_x,
  input  logic [15:0] field_y,
  input  logic [15:0] field_z,
  output logic        meas_busy,
  output logic        cmd_valid,
  output logic [7:0]  cmd_data
);

  localparam int                 c_CNT_W    = $clog2(MEAS_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEAS_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
  } state_t;

  state_t               r_state;
  logic                 r_scl_s1, r_scl_s2, r_scl_q;
  logic                 r_sda_s1, r_sda_s2, r_sda_q;
  logic [3:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 r_rw;
  logic [7:0]           r_ptr;
  logic                 r_sda_low;
  logic                 r_addressed;  // a transaction to us is open until STOP
  logic                 r_pending;    // shadow waiting to be published at STOP
  logic [47:0]          r_data;       // byte n = register 0x0n
  logic [47:0]          r_shadow;
  logic                 r_status_done;
  logic [7:0]           r_ctrl1;
  logic                 r_meas_busy;
  logic [c_CNT_W-1:0]   r_meas_cnt;
  logic                 r_cmd_valid;
  logic [7:0]           r_cmd_data;

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_defer;
  logic [7:0] w_rd_byte;

  assign w_scl_rise = r_scl_s2 & ~r_scl_q;
  assign w_scl_fall = ~r_scl_s2 & r_scl_q;
  assign w_start    = r_scl_s2 & r_scl_q & r_sda_q & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_q & ~r_sda_q & r_sda_s2;
  // A STOP in the completion cycle closes the transaction, so publish at once.
  assign w_defer    = r_addressed & ~w_stop;

  assign sda_drive_low = r_sda_low;
  assign meas_busy     = r_meas_busy;
  assign cmd_valid     = r_cmd_valid;
  assign cmd_data      = r_cmd_data;

  always_comb begin
    w_rd_byte = 8'h00;
    if (r_ptr < 8'd6)
      w_rd_byte = r_data[{r_ptr[2:0], 3'b000} +: 8];
    else if (r_ptr == 8'h06)
      w_rd_byte = {7'b0, r_status_done};
    else if (r_ptr == 8'h08)
      w_rd_byte = r_ctrl1;
    else if (r_ptr == 8'h20)
      w_rd_byte = PRODUCT_ID;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_scl_s1      <= 1'b1;
      r_scl_s2      <= 1'b1;
      r_scl_q       <= 1'b1;
      r_sda_s1      <= 1'b1;
      r_sda_s2      <= 1'b1;
      r_sda_q       <= 1'b1;
      r_bit_cnt     <= 4'd0;
      r_shift       <= 8'h00;
      r_rw          <= 1'b0;
      r_ptr         <= 8'h00;
      r_sda_low     <= 1'b0;
      r_addressed   <= 1'b0;
      r_pending     <= 1'b0;
      r_data        <= 48'h0;
      r_shadow      <= 48'h0;
      r_status_done <= 1'b0;
      r_ctrl1       <= 8'h00;
      r_meas_busy   <= 1'b0;
      r_meas_cnt    <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_data    <= 8'h00;
    end else begin
      r_scl_s1    <= scl_in;
      r_scl_s2    <= r_scl_s1;
      r_scl_q     <= r_scl_s2;
      r_sda_s1    <= sda_in;
      r_sda_s2    <= r_sda_s1;
      r_sda_q     <= r_sda_s2;
      r_cmd_valid <= 1'b0;

      if (w_stop) begin
        r_state     <= S_IDLE;
        r_sda_low   <= 1'b0;
        r_addressed <= 1'b0;
        r_pending   <= 1'b0;
        if (r_pending)
          r_data <= r_shadow;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_low <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              if (r_shift[7:1] == DEV_ADDR) begin
                r_sda_low   <= 1'b1;
                r_rw        <= r_shift[0];
                r_addressed <= 1'b1;
                r_state     <= S_ADDR_ACK;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                // first read byte: MSB goes out on the ACK-release edge
                r_sda_low <= ~w_rd_byte[7];
                r_shift   <= {w_rd_byte[6:0], 1'b0};
                r_state   <= S_RDATA;
              end else begin
                r_sda_low <= 1'b0;
                r_state   <= S_REG;
              end
            end
          end
          S_REG, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_sda_low <= 1'b1;
              if (r_state == S_REG) begin
                r_ptr   <= r_shift;
                r_state <= S_REG_ACK;
              end else begin
                if (r_ptr == 8'h07) begin
                  r_cmd_valid <= 1'b1;
                  r_cmd_data  <= r_shift;
                  if (r_shift[0] && !r_meas_busy) begin
                    r_status_done <= 1'b0;
                    r_meas_busy   <= 1'b1;
                    r_meas_cnt    <= c_CNT_LOAD;
                  end
                end else if (r_ptr == 8'h08) begin
                  r_ctrl1 <= r_shift;
                end
                r_ptr   <= r_ptr + 8'd1;
                r_state <= S_WDATA_ACK;
              end
            end
          end
          S_REG_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_low <= 1'b0;
                r_state   <= S_RACK;
              end else begin
                r_sda_low <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
              end
            end
          end
          S_RACK: begin
            // falls and rises alternate, so the fall here follows the ACK rise
            if (w_scl_rise) begin
              if (r_sda_s2)
                r_state <= S_IDLE;
              else
                r_ptr <= r_ptr + 8'd1;
            end else if (w_scl_fall) begin
              r_sda_low <= ~w_rd_byte[7];
              r_shift   <= {w_rd_byte[6:0], 1'b0};
              r_bit_cnt <= 4'd0;
              r_state   <= S_RDATA;
            end
          end
          default: ;
        endcase
      end

      // Measurement counter; placed last so completion wins over the STOP copy.
      if (r_meas_busy) begin
        if (r_meas_cnt == '0) begin
          r_meas_busy   <= 1'b0;
          r_status_done <= 1'b1;
          r_shadow      <= {field_z, field_y, field_x};
          if (w_defer)
            r_pending <= 1'b1;
          else
            r_data <= {field_z, field_y, field_x};
        end else begin
          r_meas_cnt <= r_meas_cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
